imem_loader: RTL
================

# imem_loader

Boot-time program loader that fills the KGP-RISC instruction memory from an 8-bit byte stream. It writes the memory port that the datapath's fetch stage reads. While loading, it holds the processor in reset through `cpu_hold`. It assembles big-endian 32-bit words and writes them to consecutive word addresses from 0. It checks an XOR checksum, then releases the CPU on success or latches an error on failure.

## Interface
Parameters:
- `ADDR_W`, default 10: instruction memory word-address width. Capacity is 2^ADDR_W words.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rx_valid` in 1: byte available on `rx_data`.
- `rx_data` in 8: stream byte.
- `rx_ready` out 1: loader accepts a byte. A byte transfers on a cycle where `rx_valid & rx_ready`.
- `mem_we` out 1: instruction memory write enable, one-cycle pulse per word.
- `mem_addr` out ADDR_W: word address for the write.
- `mem_din` out 32: instruction word.
- `cpu_hold` out 1: hold the processor in reset.
- `done` out 1: load completed and checksum matched.
- `err` out 1: load failed.
- `words_loaded` out ADDR_W+1: number of words written so far.
- `reload` in 1: re-arm request, honoured only in DONE or ERR.

## Operation
- Frame format:
  - LEN_HI, LEN_LO: word count N, 16-bit big-endian.
  - N×4 data bytes: each word big-endian, so byte 0 lands in `[31:24]`.
  - CSUM byte: must equal the XOR of all preceding frame bytes, length bytes included.
- FSM states: S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR.
- Transitions:
  - S_LEN_HI → S_LEN_LO on handshake.
  - S_LEN_LO → S_DATA if 0 < N ≤ 2^ADDR_W; → S_CSUM if N == 0; → S_ERR if N > 2^ADDR_W.
  - S_DATA → S_CSUM when the 4th byte of word N−1 is accepted.
  - S_CSUM → S_DONE if the byte matches the running XOR; otherwise → S_ERR.
  - S_DONE / S_ERR → S_LEN_HI on `reload`.
- Byte position within a word: 2-bit counter. Word address counter: ADDR_W+1 bits. Running XOR: 8-bit register, cleared on entry to S_LEN_HI.
- `rx_ready` = 1 in S_LEN_HI, S_LEN_LO, S_DATA and S_CSUM; 0 in S_DONE and S_ERR. Bytes offered in S_DONE/S_ERR are not consumed.
- `cpu_hold` = 1 in every state except S_DONE.
- `done` = 1 only in S_DONE; `err` = 1 only in S_ERR.
- `reload` in any state other than S_DONE/S_ERR is ignored.
- Memory contents are never cleared. Words beyond N keep their previous values.

## Timing
- Reset values:
  - state S_LEN_HI
  - `cpu_hold` 1, `rx_ready` 1
  - `mem_we` 0, `mem_addr` 0, `mem_din` 0
  - `done` 0, `err` 0, `words_loaded` 0
- Write pulse: the 4th byte of word k is accepted at cycle t. In cycle t+1, `mem_we` = 1, `mem_addr` = k and `mem_din` = the assembled word. `words_loaded` becomes k+1 at t+1.
- Back-to-back bytes every cycle are sustained; `rx_ready` never drops for a write.
- Accepting the CSUM byte at cycle t gives `done` (or `err`) = 1 at t+1. On success, `cpu_hold` falls at t+1.
- `reload` sampled at cycle t:
  - at t+1, state is S_LEN_HI, `done` = `err` = 0, `cpu_hold` = 1, `words_loaded` = 0;
  - XOR and counters are cleared.
- `rst` mid-frame: the partial word is discarded, no write is issued, all registers return to reset values next cycle, and the next byte is treated as LEN_HI.
- N == 2^ADDR_W: the last write lands at address 2^ADDR_W−1 with no wrap. `words_loaded` = 2^ADDR_W.
- Gaps in `rx_valid` stall the FSM with no side effects.

## Structure
- Shared package `kgp_pkg`: state encoding enum for the six states, the frame constants (length bytes = 2, bytes per word = 4), and `IMEM_ADDR_W` = 10.
- One sub-module is natural: `word_assembler`. It contains the byte shift register, the 2-bit byte counter and a word-complete strobe. The FSM, address counter and XOR stay in `imem_loader`.
- Top-level integration:
  - the loader's port drives the write side of the instruction memory;
  - processor reset = `rst | cpu_hold`.

## Test plan
- Two-word load: stream `00 02 DE AD BE EF 01 23 45 67 CS` with CS = 0x02^0xDE^0xAD^0xBE^0xEF^0x01^0x23^0x45^0x67. Expect writes (0, 0xDEADBEEF) and (1, 0x01234567), then `done` = 1 and `cpu_hold` = 0 one cycle after CS is accepted.
- Bad checksum: same frame with CS^0x01. Expect both writes, then `err` = 1, `cpu_hold` stays 1, `rx_ready` = 0.
- Oversize length: LEN = 0x0401 with ADDR_W = 10. Expect S_ERR right after LEN_LO and no `mem_we` pulses.
- Zero length: stream `00 00 00`. Expect no writes, then `done` = 1.
- Mid-frame reset and reload:
  - Assert `rst` after the 2nd data byte. Expect no write, and a fresh frame then loads correctly.
  - After `done`, pulse `reload`. Expect `cpu_hold` = 1 next cycle and a second frame overwrites address 0.
- Throughput and stalls: 1024-word frame with random `rx_valid` gaps. Expect every address 0–1023 written exactly once, `words_loaded` = 1024 and `done` = 1.

Source files
------------

// File: rtl/kgp_pkg.sv
// Shared KGP-RISC loader definitions: loader FSM encoding and boot frame layout.
package kgp_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int IMEM_ADDR_W    = 10;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words.
// The word-complete strobe fires in the same cycle as the word's 4th byte.
module word_assembler
  import kgp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic        word_vld_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q;
  logic [23:0] sr_q;

  // The completed word includes the byte that is arriving now.
  assign word_vld_o = byte_vld_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_o     = {sr_q, byte_i};

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (byte_vld_i) begin
      cnt_q <= cnt_q + 2'd1;
    end
  end

  // A partial word left here after a reset is harmless: cnt_q restarts at 0.
  always_ff @(posedge clk) begin
    if (byte_vld_i) begin
      sr_q <= {sr_q[15:0], byte_i};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte frame into the instruction memory,
// holds the CPU in reset while loading, and releases it on a good XOR checksum.
module imem_loader
  import kgp_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded,
  input  logic              reload
);

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [7:0]        len_hi_q;
  logic [15:0]       n_q;
  logic [ADDR_W:0]   wcnt_q;
  logic [ADDR_W:0]   wcnt_nxt;
  logic [7:0]        xor_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_din_q;
  logic              rx_ready_q, cpu_hold_q, done_q, err_q;

  logic              hs;
  logic [15:0]       len_n;
  logic              do_reload;
  logic              word_vld;
  logic [31:0]       word;
  logic              last_word;

  assign hs        = rx_valid && rx_ready_q;
  assign len_n     = {len_hi_q, rx_data};
  assign do_reload = reload && (state_q == S_DONE || state_q == S_ERR);
  assign wcnt_nxt  = wcnt_q + 1'b1;
  assign last_word = 17'(wcnt_nxt) == {1'b0, n_q};

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (do_reload),
    .byte_vld_i (hs && state_q == S_DATA),
    .byte_i     (rx_data),
    .word_vld_o (word_vld),
    .word_o     (word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN_HI: if (hs) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (hs) begin
          if (len_n == 16'd0)           state_d = S_CSUM;
          else if ({1'b0, len_n} > CAP) state_d = S_ERR;
          else                          state_d = S_DATA;
        end
      end
      S_DATA:   if (word_vld && last_word) state_d = S_CSUM;
      S_CSUM:   if (hs) state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
      S_DONE,
      S_ERR:    if (reload) state_d = S_LEN_HI;
      default:  state_d = S_LEN_HI;
    endcase
  end

  // Status outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LEN_HI;
      len_hi_q   <= '0;
      n_q        <= '0;
      wcnt_q     <= '0;
      xor_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rx_ready_q <= 1'b1;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= (state_d != S_DONE) && (state_d != S_ERR);
      cpu_hold_q <= (state_d != S_DONE);
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERR);
      mem_we_q   <= word_vld;
      if (word_vld) begin
        mem_addr_q <= wcnt_q[ADDR_W-1:0];
        mem_din_q  <= word;
        wcnt_q     <= wcnt_nxt;
      end
      if (hs && state_q == S_LEN_HI) len_hi_q <= rx_data;
      if (hs && state_q == S_LEN_LO) n_q <= len_n;
      if (hs && state_q != S_CSUM)   xor_q <= xor_q ^ rx_data;
      if (do_reload) begin
        xor_q  <= '0;
        wcnt_q <= '0;
      end
    end
  end

  assign rx_ready     = rx_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_din      = mem_din_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wcnt_q;

endmodule
